output_port_cluster_arb: RTL and testbench

Parametrised successor to the per-port output cluster. It accepts payloads from NUM_OUT_PORTS user channels and buffers each channel in its own FIFO. Each payload is packetised with that port's destination leaf, destination port and remote FIFO address. A credit-gated round-robin arbiter merges all channels onto a single registered packet stream towards the leaf interface. Per-port credit (freespace) and remote-address state live here, so user logic needs only a valid/ack handshake.

---
 rtl/output_port_cluster_arb.sv | 176 +++++++++++++++++
 tb/tb_output_port_cluster_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_cluster_arb.sv
// Output port cluster: per-port payload FIFOs, per-port credit / remote
// address / destination state, and a credit-gated round-robin arbiter that
// merges all channels onto one registered packet stream.
module output_port_cluster_arb #(
  parameter int unsigned NUM_OUT_PORTS = 7,
  parameter int unsigned PAYLOAD_BITS  = 64,
  parameter int unsigned NUM_LEAF_BITS = 6,
  parameter int unsigned NUM_PORT_BITS = 4,
  parameter int unsigned NUM_ADDR_BITS = 7,
  parameter int unsigned FIFO_DEPTH    = 4,
  localparam int unsigned PORT_SEL_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1,
  localparam int unsigned CFG_DATA_BITS =
    ((NUM_LEAF_BITS + NUM_PORT_BITS) > (NUM_ADDR_BITS + 1)) ?
    (NUM_LEAF_BITS + NUM_PORT_BITS) : (NUM_ADDR_BITS + 1),
  localparam int unsigned PACKET_BITS =
    NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cfg_wr_en,
  input  logic [PORT_SEL_BITS-1:0]              cfg_port_sel,
  input  logic [1:0]                            cfg_op,
  input  logic [CFG_DATA_BITS-1:0]              cfg_data,
  input  logic [PAYLOAD_BITS*NUM_OUT_PORTS-1:0] user_din,
  input  logic [NUM_OUT_PORTS-1:0]              user_vld,
  output logic [NUM_OUT_PORTS-1:0]              user_ack,
  output logic [PACKET_BITS-1:0]                pkt_out,
  output logic                                  pkt_vld,
  input  logic                                  pkt_rdy,
  output logic [NUM_OUT_PORTS-1:0]              port_stalled
);

  localparam int unsigned N        = NUM_OUT_PORTS;
  localparam int unsigned PW       = PAYLOAD_BITS;
  localparam int unsigned AW       = NUM_ADDR_BITS;
  localparam int unsigned CW       = NUM_ADDR_BITS + 1;
  localparam int unsigned DW       = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int unsigned FAW      = $clog2(FIFO_DEPTH);
  localparam int unsigned FPW      = FAW + 1;
  localparam int unsigned SW       = CFG_DATA_BITS + 2;
  localparam int unsigned CRED_MAX = 1 << NUM_ADDR_BITS;

  logic [PW-1:0]            mem_q    [N][FIFO_DEPTH];
  logic [FPW-1:0]           wptr_q   [N];
  logic [FPW-1:0]           rptr_q   [N];
  logic [CW-1:0]            credit_q [N];
  logic [CW-1:0]            credit_d [N];
  logic [SW-1:0]            cred_raw [N];
  logic [AW-1:0]            addr_q   [N];
  logic [AW-1:0]            addr_d   [N];
  logic [DW-1:0]            dst_q    [N];
  logic [DW-1:0]            dst_d    [N];
  logic [PORT_SEL_BITS-1:0] rr_q;
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
  logic                     vld_q, vld_d;
  logic [N-1:0]             stall_q, stall_d;
  logic [N-1:0]             full, nempty, elig, push, pop, cfg_hit;
  logic                     gnt_vld;
  logic [PORT_SEL_BITS-1:0] gnt_idx;
  logic [PORT_SEL_BITS-1:0] cand;
  logic [PW-1:0]            head;

  // Per-port FIFO status, eligibility, handshake and config decode
  always_comb begin
    full    = '0;
    nempty  = '0;
    elig    = '0;
    push    = '0;
    cfg_hit = '0;
    for (int i = 0; i < int'(N); i++) begin
      full[i]    = (wptr_q[i][FAW] != rptr_q[i][FAW]) &&
                   (wptr_q[i][FAW-1:0] == rptr_q[i][FAW-1:0]);
      nempty[i]  = (wptr_q[i] != rptr_q[i]);
      elig[i]    = nempty[i] && (credit_q[i] != '0);
      push[i]    = user_vld[i] && !full[i];
      cfg_hit[i] = cfg_wr_en && (cfg_port_sel == PORT_SEL_BITS'(i));
    end
  end

  // Round-robin pick: first eligible port strictly after the last grant
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!vld_q || pkt_rdy) begin
      for (int k = 1; k <= int'(N); k++) begin
        cand = PORT_SEL_BITS'((int'(rr_q) + k) % int'(N));
        if (!gnt_vld && elig[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign pop  = gnt_vld ? (N'(1) << gnt_idx) : '0;
  assign head = mem_q[gnt_idx][rptr_q[gnt_idx][FAW-1:0]];

  // Output register next state: load on grant, drain on accept, else hold
  always_comb begin
    vld_d = vld_q;
    pkt_d = pkt_q;
    if (gnt_vld) begin
      vld_d = 1'b1;
      pkt_d = {dst_q[gnt_idx], addr_q[gnt_idx], head};
    end else if (vld_q && pkt_rdy) begin
      vld_d = 1'b0;
    end
  end

  // Per-port credit / address / destination next state; config first, grant on top
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      cred_raw[i] = SW'(credit_q[i]);
      addr_d[i]   = addr_q[i];
      dst_d[i]    = dst_q[i];
      if (cfg_hit[i]) begin
        case (cfg_op)
          2'b00: dst_d[i]    = cfg_data[DW-1:0];
          2'b01: cred_raw[i] = SW'(cfg_data[AW:0]);
          2'b10: cred_raw[i] = SW'(credit_q[i]) + SW'(cfg_data);
          2'b11: addr_d[i]   = cfg_data[AW-1:0];
        endcase
      end
      if (pop[i]) begin
        if (cred_raw[i] != '0) cred_raw[i] = cred_raw[i] - SW'(1);
        addr_d[i] = addr_d[i] + AW'(1);
      end
      credit_d[i] = (cred_raw[i] > SW'(CRED_MAX)) ? CW'(CRED_MAX) : CW'(cred_raw[i]);
      stall_d[i]  = ((wptr_q[i] + FPW'(push[i])) != (rptr_q[i] + FPW'(pop[i]))) &&
                    (credit_d[i] == '0);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N); i++) begin
        wptr_q[i]   <= '0;
        rptr_q[i]   <= '0;
        credit_q[i] <= '0;
        addr_q[i]   <= '0;
        dst_q[i]    <= '0;
      end
      rr_q    <= '0;
      pkt_q   <= '0;
      vld_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + FPW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + FPW'(1);
        credit_q[i] <= credit_d[i];
        addr_q[i]   <= addr_d[i];
        dst_q[i]    <= dst_d[i];
      end
      if (gnt_vld) rr_q <= gnt_idx;
      pkt_q   <= pkt_d;
      vld_q   <= vld_d;
      stall_q <= stall_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (push[i]) mem_q[i][wptr_q[i][FAW-1:0]] <= user_din[i*PW +: PW];
    end
  end

  assign user_ack     = ~full;
  assign pkt_out      = pkt_q;
  assign pkt_vld      = vld_q;
  assign port_stalled = stall_q;

endmodule

// File: tb/tb_output_port_cluster_arb.sv
// Bench for output_port_cluster_arb: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_output_port_cluster_arb;

  localparam int N   = 7;
  localparam int PB  = 64;
  localparam int LB  = 6;
  localparam int PTB = 4;
  localparam int AB  = 7;
  localparam int FD  = 4;
  localparam int PSW = 3;
  localparam int CDB = 10;
  localparam int PKB = 81;
  localparam int CMAX = 128;

  logic            clk = 1'b0;
  logic            reset;
  logic            cfg_wr_en;
  logic [PSW-1:0]  cfg_port_sel;
  logic [1:0]      cfg_op;
  logic [CDB-1:0]  cfg_data;
  logic [PB*N-1:0] user_din;
  logic [N-1:0]    user_vld;
  logic [N-1:0]    user_ack;
  logic [PKB-1:0]  pkt_out;
  logic            pkt_vld;
  logic            pkt_rdy;
  logic [N-1:0]    port_stalled;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  output_port_cluster_arb #(
    .NUM_OUT_PORTS(N), .PAYLOAD_BITS(PB), .NUM_LEAF_BITS(LB),
    .NUM_PORT_BITS(PTB), .NUM_ADDR_BITS(AB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_port_sel(cfg_port_sel),
    .cfg_op(cfg_op), .cfg_data(cfg_data), .user_din(user_din), .user_vld(user_vld),
    .user_ack(user_ack), .pkt_out(pkt_out), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
    .port_stalled(port_stalled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [PB-1:0]  mq [N][$];
  int             m_credit [N];
  int             m_addr   [N];
  logic [LB-1:0]  m_leaf   [N];
  logic [PTB-1:0] m_dport  [N];
  int             m_rr = 0;
  logic           m_vld = 1'b0;
  logic [PKB-1:0] m_pkt = '0;

  always @(posedge clk or negedge reset) begin
    int g, sel, pc, v;
    logic [N-1:0] pushes;
    logic [CDB-1:0] d;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        mq[i].delete();
        m_credit[i] = 0; m_addr[i] = 0; m_leaf[i] = '0; m_dport[i] = '0;
      end
      m_rr = 0; m_vld = 1'b0; m_pkt = '0;
    end else begin
      for (int i = 0; i < N; i++) pushes[i] = user_vld[i] && (mq[i].size() < FD);
      sel = int'(cfg_port_sel);
      d   = cfg_data;
      pc  = (sel < N) ? m_credit[sel] : 0;
      g = -1;
      if (!m_vld || pkt_rdy) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_rr + k) % N;
          if (g < 0 && mq[c].size() > 0 && m_credit[c] > 0) g = c;
        end
      end
      if (g >= 0) begin
        m_pkt = {m_leaf[g], m_dport[g], AB'(m_addr[g]), mq[g].pop_front()};
        m_vld = 1'b1;
        m_rr  = g;
        m_credit[g] = m_credit[g] - 1;
        m_addr[g]   = (m_addr[g] + 1) % CMAX;
      end else if (m_vld && pkt_rdy) begin
        m_vld = 1'b0;
      end
      if (cfg_wr_en && sel < N) begin
        case (cfg_op)
          2'd0: begin m_leaf[sel] = d[9:4]; m_dport[sel] = d[3:0]; end
          2'd1: begin
            v = int'(d[7:0]);
            if (g == sel && v > 0) v = v - 1;
            m_credit[sel] = (v > CMAX) ? CMAX : v;
          end
          2'd2: begin
            v = pc + int'(d);
            if (g == sel) v = v - 1;
            m_credit[sel] = (v > CMAX) ? CMAX : v;
          end
          default: m_addr[sel] = (int'(d[6:0]) + ((g == sel) ? 1 : 0)) % CMAX;
        endcase
      end
      for (int i = 0; i < N; i++)
        if (pushes[i]) mq[i].push_back(user_din[i*PB +: PB]);
    end
  end

  // ---------------- per-cycle compare + accept monitor ----------------
  typedef struct { int c; logic [PKB-1:0] p; } acc_t;
  acc_t acc_q[$];

  always @(negedge clk) begin
    logic [N-1:0] e_ack, e_st;
    for (int i = 0; i < N; i++) begin
      e_ack[i] = mq[i].size() < FD;
      e_st[i]  = (mq[i].size() > 0) && (m_credit[i] == 0);
    end
    check("pkt_vld", pkt_vld, m_vld);
    if (m_vld) check("pkt_out", pkt_out, m_pkt);
    check("user_ack", user_ack, e_ack);
    check("port_stalled", port_stalled, e_st);
    if (pkt_vld && pkt_rdy) acc_q.push_back('{cyc, pkt_out});
  end

  // ---------------- stimulus helpers ----------------
  function automatic int f_leaf(input logic [PKB-1:0] p); return int'(p[80:75]); endfunction
  function automatic int f_port(input logic [PKB-1:0] p); return int'(p[74:71]); endfunction
  function automatic int f_addr(input logic [PKB-1:0] p); return int'(p[70:64]); endfunction

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_reset();
    reset = 1'b0; cfg_wr_en = 1'b0; user_vld = '0; pkt_rdy = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic cfg_w(input int p, input int op, input int data);
    cfg_wr_en = 1'b1; cfg_port_sel = PSW'(p); cfg_op = 2'(op); cfg_data = CDB'(data);
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic push1(input int p, input logic [PB-1:0] d);
    bit ok;
    ok = 1'b0;
    user_din[p*PB +: PB] = d;
    user_vld[p] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (user_ack[p]) begin ok = 1'b1; tick(); break; end
      tick();
    end
    user_vld[p] = 1'b0;
    check("push_accepted", ok, 1'b1);
  endtask

  function automatic int count_port(input int p);
    int n = 0;
    foreach (acc_q[k]) if (f_port(acc_q[k].p) == p) n++;
    return n;
  endfunction

  initial begin
    int acc;
    logic [PKB-1:0] cap;
    int ord[3];
    logic [PB-1:0] pl [5];
    reset = 1'b0; cfg_wr_en = 1'b0; cfg_port_sel = '0; cfg_op = '0; cfg_data = '0;
    user_din = '0; user_vld = '0; pkt_rdy = 1'b1;

    // Reset state and FIFO fill with no credit
    do_reset();
    check("rst_pkt_vld", pkt_vld, 1'b0);
    check("rst_pkt_out", pkt_out, '0);
    check("rst_user_ack", user_ack, 7'h7f);
    check("rst_stalled", port_stalled, 7'h00);
    acc = 0;
    user_vld[0] = 1'b1;
    for (int t = 0; t < 6; t++) begin
      user_din[PB-1:0] = {$urandom, $urandom};
      if (user_ack[0]) acc++;
      tick();
    end
    user_vld = '0;
    check("fill_accepted", acc, 4);
    check("fill_ack0", user_ack[0], 1'b0);
    check("fill_stalled0", port_stalled[0], 1'b1);
    check("fill_pkt_vld", pkt_vld, 1'b0);

    // Credit gating and address sequencing on port 2
    do_reset();
    cfg_w(2, 0, (5 << 4) | 3);
    cfg_w(2, 1, 3);
    acc_q.delete();
    for (int k = 0; k < 5; k++) begin
      pl[k] = 64'hA0A0_0000_0000_0000 + 64'(k);
      push1(2, pl[k]);
    end
    repeat (8) tick();
    check("p2_count3", acc_q.size(), 3);
    if (acc_q.size() == 3)
      for (int k = 0; k < 3; k++) begin
        check("p2_leaf", f_leaf(acc_q[k].p), 5);
        check("p2_port", f_port(acc_q[k].p), 3);
        check("p2_addr", f_addr(acc_q[k].p), k);
        check("p2_payload", acc_q[k].p[63:0], pl[k]);
      end
    cfg_w(2, 2, 2);
    repeat (6) tick();
    check("p2_count5", acc_q.size(), 5);
    if (acc_q.size() == 5)
      for (int k = 3; k < 5; k++) begin
        check("p2_addr_more", f_addr(acc_q[k].p), k);
        check("p2_payload_more", acc_q[k].p[63:0], pl[k]);
      end

    // Round-robin over ports 0, 3, 6 at full rate
    do_reset();
    cfg_w(0, 0, 0); cfg_w(3, 0, 3); cfg_w(6, 0, 6);
    cfg_w(6, 1, 1);
    push1(6, 64'hDEAD);
    repeat (4) tick();
    acc_q.delete();
    cfg_w(0, 1, 10); cfg_w(3, 1, 10); cfg_w(6, 1, 10);
    ord = '{0, 3, 6};
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) begin
        user_vld[ord[j]] = 1'b1;
        user_din[ord[j]*PB +: PB] = 64'(ord[j] * 256 + r);
      end
      tick();
    end
    user_vld = '0;
    repeat (20) tick();
    check("rr_count", acc_q.size(), 12);
    if (acc_q.size() == 12)
      for (int k = 0; k < 12; k++) begin
        check("rr_order", f_port(acc_q[k].p), ord[k % 3]);
        check("rr_payload", acc_q[k].p[63:0], 64'(ord[k % 3] * 256 + k / 3));
        check("rr_back_to_back", acc_q[k].c, acc_q[0].c + k);
      end

    // Remote address wrap
    do_reset();
    cfg_w(4, 3, 126);
    cfg_w(4, 1, 4);
    acc_q.delete();
    for (int k = 0; k < 3; k++) push1(4, 64'(k + 1));
    repeat (6) tick();
    check("wrap_count", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check("wrap_addr0", f_addr(acc_q[0].p), 126);
      check("wrap_addr1", f_addr(acc_q[1].p), 127);
      check("wrap_addr2", f_addr(acc_q[2].p), 0);
    end

    // Backpressure hold then back-to-back release
    do_reset();
    cfg_w(5, 1, 10);
    pkt_rdy = 1'b0;
    for (int k = 0; k < 3; k++) push1(5, 64'h5500 + 64'(k));
    check("bp_vld", pkt_vld, 1'b1);
    cap = pkt_out;
    check("bp_first_payload", cap[63:0], 64'h5500);
    for (int t = 0; t < 5; t++) begin
      tick();
      check("bp_hold_out", pkt_out, cap);
      check("bp_hold_vld", pkt_vld, 1'b1);
    end
    acc_q.delete();
    pkt_rdy = 1'b1;
    repeat (5) tick();
    check("bp_count", acc_q.size(), 3);
    if (acc_q.size() == 3)
      for (int k = 0; k < 3; k++) begin
        check("bp_b2b", acc_q[k].c, acc_q[0].c + k);
        check("bp_payload", acc_q[k].p[63:0], 64'h5500 + 64'(k));
      end

    // Add credit in the grant cycle, saturation, mid-stream reset
    do_reset();
    cfg_w(1, 0, 1);
    push1(1, 64'h11);
    push1(1, 64'h12);
    acc_q.delete();
    cfg_w(1, 1, 1);
    cfg_w(1, 2, 5);
    user_vld[1] = 1'b1;
    for (int t = 0; t < 40; t++) begin user_din[PB +: PB] = {$urandom, $urandom}; tick(); end
    user_vld = '0;
    repeat (5) tick();
    check("addgrant_total", count_port(1), 6);
    check("addgrant_stalled", port_stalled[1], 1'b1);
    acc_q.delete();
    cfg_w(1, 1, 200);
    user_vld[1] = 1'b1;
    for (int t = 0; t < 145; t++) begin user_din[PB +: PB] = {$urandom, $urandom}; tick(); end
    user_vld = '0;
    repeat (5) tick();
    check("sat_total", count_port(1), 128);
    cfg_w(0, 1, 50);
    cfg_w(1, 1, 50);
    user_vld[1:0] = 2'b11;
    repeat (10) tick();
    check("pre_reset_vld", pkt_vld, 1'b1);
    reset = 1'b0;
    #1;
    check("async_rst_vld", pkt_vld, 1'b0);
    check("async_rst_ack", user_ack, 7'h7f);
    repeat (2) tick();
    user_vld = '0;
    reset = 1'b1;
    tick();
    push1(0, 64'h1);
    push1(1, 64'h2);
    repeat (3) tick();
    check("post_rst_stalled", port_stalled[1:0], 2'b11);
    check("post_rst_vld", pkt_vld, 1'b0);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      user_vld = N'($urandom);
      for (int p = 0; p < N; p++) user_din[p*PB +: PB] = {$urandom, $urandom};
      pkt_rdy      = ($urandom % 4) != 0;
      cfg_wr_en    = ($urandom % 4) == 0;
      cfg_port_sel = PSW'($urandom_range(0, 7));
      cfg_op       = 2'($urandom);
      cfg_data     = (($urandom % 8) == 0) ? CDB'($urandom) : CDB'($urandom_range(0, 6));
      tick();
    end
    cfg_wr_en = 1'b0;
    user_vld = '0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
